// File: rtl/main_memory.sv
// Byte-addressed little-endian memory responder; one request at a time, answered LATENCY cycles
// after acceptance with a single-cycle data_valid_o pulse. Requests arriving while busy are ignored.
package main_memory_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} access_size_t;
endpackage

module main_memory
  import main_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 4096,
  parameter int LATENCY    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_req_valid_i,
  input  logic                  wr_req_valid_i,
  input  logic                  req_is_instr_i,
  input  logic [ADDR_WIDTH-1:0] req_address_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  access_size_t          req_access_size_i,
  output logic                  data_valid_o,
  output logic                  data_is_instr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);
  localparam int AW = $clog2(MEM_SIZE);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         addr_q;
  access_size_t          size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  instr_q;
  logic                  is_wr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [7:0]            mem [MEM_SIZE];

  logic                  idle, req, capture, enter_resp;
  logic [AW-1:0]         cur_addr, base;
  access_size_t          cur_size;
  logic [DATA_WIDTH-1:0] cur_wdata, rdata;
  logic                  cur_wr, is_byte, is_half;
  logic [7:0]            b0, b1, b2, b3;
  logic                  unused_addr;

  assign unused_addr = ^req_address_i[ADDR_WIDTH-1:AW];

  // With LATENCY=1 the access happens on the capture edge, so it must use the live inputs.
  assign idle      = (state_q == IDLE);
  assign req       = rd_req_valid_i | wr_req_valid_i;
  assign cur_addr  = idle ? req_address_i[AW-1:0] : addr_q;
  assign cur_size  = idle ? req_access_size_i : size_q;
  assign cur_wdata = idle ? wr_data_i : wdata_q;
  assign cur_wr    = idle ? wr_req_valid_i : is_wr_q;
  assign is_byte   = (cur_size == BYTE);
  assign is_half   = (cur_size == HALF);

  always_comb begin
    base = cur_addr;
    if (is_half)       base = {cur_addr[AW-1:1], 1'b0};
    else if (!is_byte) base = {cur_addr[AW-1:2], 2'b00};
  end

  assign b0 = mem[base];
  assign b1 = mem[base + AW'(1)];
  assign b2 = mem[base + AW'(2)];
  assign b3 = mem[base + AW'(3)];

  always_comb begin
    rdata = {b3, b2, b1, b0};
    if (is_byte)      rdata = {24'b0, b0};
    else if (is_half) rdata = {16'b0, b1, b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= BYTE;
      wdata_q <= '0;
      instr_q <= 1'b0;
      is_wr_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= req_address_i[AW-1:0];
        size_q  <= req_access_size_i;
        wdata_q <= wr_data_i;
        instr_q <= req_is_instr_i & ~wr_req_valid_i;
        is_wr_q <= wr_req_valid_i;
      end
      if (enter_resp) data_q <= cur_wr ? '0 : rdata;
    end
  end

  // Storage is deliberately not reset; a write is only committed on the edge entering RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i && enter_resp && cur_wr) begin
      mem[base] <= cur_wdata[7:0];
      if (!is_byte) mem[base + AW'(1)] <= cur_wdata[15:8];
      if (!is_byte && !is_half) begin
        mem[base + AW'(2)] <= cur_wdata[23:16];
        mem[base + AW'(3)] <= cur_wdata[31:24];
      end
    end
  end

  assign data_valid_o    = (state_q == RESP);
  assign data_is_instr_o = (state_q == RESP) & instr_q;
  assign data_o          = data_q;
  assign busy_o          = !idle;
endmodule
